prefetch_req_queue: RTL



---
 rtl/prefetch_req_queue.sv | 139 +++++++++++++
 1 files changed

// File: rtl/prefetch_req_queue.sv
// Line-aligning, de-duplicating FIFO between the slice prefetcher and the memory request port.
// Build option: define PFQ_DUP_FILTER_EN to compile in the recent-line duplicate filter.
module prefetch_req_queue #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned FILTER_N  = 4,
  parameter int unsigned LINE_BITS = 5,
  parameter int unsigned DROP_W    = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       pf_valid,
  input  logic [ADDR_W-1:0]          pf_addr,
  output logic                       req_valid,
  output logic [ADDR_W-1:0]          req_addr,
  input  logic                       req_ready,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic [DROP_W-1:0]          full_drops,
  output logic [DROP_W-1:0]          dup_drops
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] LINE_MASK = ~((ADDR_W'(1) << LINE_BITS) - ADDR_W'(1));
  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  logic [ADDR_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [ADDR_W-1:0] line_addr;
  logic [OCC_W-1:0]  occ_next;
  logic              duplicate;
  logic              pop;
  logic              full;
  logic              accept;
  logic              full_drop;

  assign line_addr = pf_addr & LINE_MASK;
  assign pop       = req_valid && req_ready;
  assign full      = (occupancy == OCC_W'(DEPTH));
  assign accept    = pf_valid && !duplicate && (!full || pop) && !flush;
  assign full_drop = pf_valid && !duplicate && !accept && !flush;

  // First-word-fall-through head; forced to zero while empty so reset/flush show 0.
  assign req_addr = req_valid ? mem[head] : '0;

  always_comb begin
    occ_next = occupancy;
    case ({accept, pop})
      2'b10:   occ_next = occupancy + OCC_W'(1);
      2'b01:   occ_next = occupancy - OCC_W'(1);
      default: occ_next = occupancy;
    endcase
  end

  // Pointers, occupancy and valid flag; flush outranks push and pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head      <= '0;
      tail      <= '0;
      occupancy <= '0;
      req_valid <= 1'b0;
    end else if (flush) begin
      head      <= '0;
      tail      <= '0;
      occupancy <= '0;
      req_valid <= 1'b0;
    end else begin
      if (accept) tail <= tail + PTR_W'(1);
      if (pop)    head <= head + PTR_W'(1);
      occupancy <= occ_next;
      req_valid <= (occ_next != '0);
    end
  end

  // Entry storage carries no reset; req_addr is masked by req_valid.
  always_ff @(posedge clk) begin
    if (accept) mem[tail] <= line_addr;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full_drops <= '0;
    end else if (full_drop && (full_drops != DROP_MAX)) begin
      full_drops <= full_drops + DROP_W'(1);
    end
  end

`ifdef PFQ_DUP_FILTER_EN
  localparam int unsigned FPTR_W = (FILTER_N > 1) ? $clog2(FILTER_N) : 1;

  logic [ADDR_W-1:0]   filt_addr [FILTER_N];
  logic [FILTER_N-1:0] filt_vld;
  logic [FPTR_W-1:0]   f_ptr;
  logic                filt_hit;
  logic                dup_drop;

  // Match against registered filter contents only; no bypass from this cycle's accept.
  always_comb begin
    filt_hit = 1'b0;
    for (int i = 0; i < FILTER_N; i++) begin
      if (filt_vld[i] && (filt_addr[i] == line_addr)) filt_hit = 1'b1;
    end
  end

  assign duplicate = pf_valid && filt_hit;
  assign dup_drop  = duplicate && !flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt_vld <= '0;
      f_ptr    <= '0;
    end else if (flush) begin
      filt_vld <= '0;
      f_ptr    <= '0;
    end else if (accept) begin
      filt_vld[f_ptr] <= 1'b1;
      f_ptr <= (f_ptr == FPTR_W'(FILTER_N - 1)) ? '0 : f_ptr + FPTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) filt_addr[f_ptr] <= line_addr;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dup_drops <= '0;
    end else if (dup_drop && (dup_drops != DROP_MAX)) begin
      dup_drops <= dup_drops + DROP_W'(1);
    end
  end
`else
  assign duplicate = 1'b0;
  assign dup_drops = '0;
`endif

endmodule
